sync_ram_sp_param: RTL and testbench
====================================

# sync_ram_sp_param

Parametrised single-port synchronous RAM with a registered read port, separate write/read data buses, and a hardware clear engine that zeroes every location after reset or on request. It is the clocked, generalised successor to the 16x8 asynchronous RAM: width, address width and depth are set per instance. It is the generic scratch/lookup memory for the team's datapath blocks.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word (>=1)
- ADDR_WIDTH, 4, address bits (>=1)
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH (need not be a power of two)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- en  in  1  access request, sampled on clk rising edge
- we  in  1  1 = write, 0 = read (meaningful only with en=1)
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- clr  in  1  request full-memory clear
- rdata  out  DATA_WIDTH  registered read data
- rvalid  out  1  one-cycle pulse: rdata holds a new read result
- oob  out  1  one-cycle pulse: accepted access had addr >= DEPTH
- busy  out  1  clear engine active; accesses ignored

## Operation
- Two-state FSM: CLEAR, IDLE. Clear counter ccnt, width ADDR_WIDTH.
- Reset (rst_n=0, async): state=CLEAR, ccnt=0, rdata=0, rvalid=0, oob=0. busy=1 (decoded from state). Array contents not reset directly.
- CLEAR, each edge: mem[ccnt]<=0; if ccnt==DEPTH-1 -> IDLE, else ccnt<=ccnt+1. Exactly DEPTH writes.
- busy = (state==CLEAR); no other logic.
- Access accepted when state==IDLE, en=1, clr=0.
- Accepted write, addr<DEPTH: mem[addr]<=wdata; rvalid=0; rdata unchanged.
- Accepted read, addr<DEPTH: rdata<=mem[addr]; rvalid<=1.
- Accepted access, addr>=DEPTH: memory untouched; oob<=1; a read also sets rdata<=0, rvalid<=1; a write gives rvalid=0.
- clr=1 in IDLE: next edge state<=CLEAR, ccnt<=0; same-cycle access dropped (clr wins).
- clr=1 in CLEAR: ccnt<=0 (restart); clear runs full DEPTH cycles from that edge.
- en=1 while busy: ignored, rvalid=0, oob=0, no memory effect.
- rdata holds last value when rvalid=0; it is not cleared by the clear engine.

## Timing
- Read latency 1: request at edge N -> rdata/rvalid valid after edge N, until edge N+1.
- Write visible to a read requested on the following edge.
- Back-to-back accesses every cycle; no throughput loss.
- Single port: one access per cycle, so no read/write collision.
- Clear after rst_n release: busy falls after the DEPTH-th rising edge; first accepted access on edge DEPTH+1.
- clr at edge N (IDLE): busy high from after edge N to after edge N+DEPTH.
- rvalid, oob: registered pulses, high one cycle per accepted access.
- Reset mid-clear or mid-access: immediate return to reset values; the clear restarts from address 0 after release.

## Test plan
- Defaults (8/4/16): release reset, hold en=1 we=0 addr=3 -> busy high 16 cycles, no rvalid; first read returns rdata=0x00, rvalid=1.
- Write addr k <- k+0xA0 for k=0..15 back-to-back, then read 0..15 back-to-back -> rdata=0xA0..0xAF, rvalid high 16 consecutive cycles, 1-cycle latency.
- Write addr 5=0x5A; next cycle read 5 -> 0x5A; idle cycles -> rdata holds 0x5A, rvalid=0.
- After filling memory, pulse clr with same-cycle write addr 2=0xFF -> busy 16 cycles, write dropped; read all -> 0x00. Pulse clr again mid-clear at cycle 8 -> busy lasts 16 cycles from restart.
- DEPTH=12, ADDR_WIDTH=4: write addr 13=0x77 -> oob pulse, no rvalid, mem unchanged; read addr 13 -> rdata=0x00, rvalid=1, oob=1; read addr 11 -> valid, oob=0.
- Assert rst_n=0 mid-read burst -> rdata=0, rvalid=0, busy=1 immediately (no clock edge); after release, full 16-cycle clear, memory reads 0.

Source files
------------

// File: rtl/sync_ram_sp_param_if.sv
// -----------------------------------------------------------------------------
// sync_ram_sp_param_if
// Access bus for the single-port synchronous RAM.
//   en     access request (sampled on rising clk)
//   we     1 = write, 0 = read
//   addr   word address
//   wdata  write data
//   clr    request full-memory clear
//   rdata  registered read data
//   rvalid one-cycle pulse: rdata holds a new read result
//   oob    one-cycle pulse: accepted access addressed past the last word
//   busy   clear engine active; accesses are ignored
// master = requester side, slave = RAM side.
// -----------------------------------------------------------------------------
interface sync_ram_sp_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  oob;
  logic                  busy;

  modport master (
    output en, we, addr, wdata, clr,
    input  rdata, rvalid, oob, busy
  );

  modport slave (
    input  en, we, addr, wdata, clr,
    output rdata, rvalid, oob, busy
  );
endinterface

// File: rtl/sync_ram_sp_param.sv
// -----------------------------------------------------------------------------
// sync_ram_sp_param
// Parametrised single-port synchronous RAM with a registered read port and a
// hardware clear engine that zeroes every word after reset or on request.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    sync_ram_sp_param_if.slave: en/we/addr/wdata/clr in,
//          rdata/rvalid/oob/busy out
// Parameters: DATA_WIDTH bits per word, ADDR_WIDTH address bits,
//   DEPTH words (1 <= DEPTH <= 2**ADDR_WIDTH, need not be a power of two).
// -----------------------------------------------------------------------------
module sync_ram_sp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_ram_sp_param_if.slave  bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the compare.
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ccnt;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  rvalid_p1;
  logic                  oob_p1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // clr wins over a same-cycle access.
  assign accept   = (state == IDLE) && bus.en && !bus.clr;
  assign in_range = {1'b0, bus.addr} < DEPTH_X;

  // The clear engine and the access port share the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.wdata;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = ccnt;
      mem_wdata = '0;
    end else if (accept && bus.we && in_range) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array is never reset; the clear engine zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // ---- stage p1: control FSM and registered read port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      ccnt      <= '0;
      rdata_p1  <= '0;
      rvalid_p1 <= 1'b0;
      oob_p1    <= 1'b0;
    end else begin
      rvalid_p1 <= 1'b0;
      oob_p1    <= 1'b0;
      case (state)
        CLEAR: begin
          // A clr during clearing restarts the sweep from word 0.
          if (bus.clr) begin
            ccnt <= '0;
          end else if (ccnt == LAST) begin
            state <= IDLE;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.clr) begin
            state <= CLEAR;
            ccnt  <= '0;
          end else if (accept) begin
            if (in_range) begin
              if (!bus.we) begin
                rdata_p1  <= mem[bus.addr];
                rvalid_p1 <= 1'b1;
              end
            end else begin
              // Out-of-range reads return zero rather than holding old data.
              oob_p1 <= 1'b1;
              if (!bus.we) begin
                rdata_p1  <= '0;
                rvalid_p1 <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= CLEAR;
          ccnt  <= '0;
        end
      endcase
    end
  end

  assign bus.rdata  = rdata_p1;
  assign bus.rvalid = rvalid_p1;
  assign bus.oob    = oob_p1;
  assign bus.busy   = (state == CLEAR);

endmodule

// File: tb/tb_sync_ram_sp_param.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_sp_param
// Bench for sync_ram_sp_param: instance A uses the defaults (8/4/16), instance
// B uses DEPTH=12 to exercise out-of-range addresses. Both see the same bus
// stimulus; each expectation names which instance it applies to.
// -----------------------------------------------------------------------------
module tb_sync_ram_sp_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en;
  logic       we;
  logic       clr;
  logic [3:0] addr;
  logic [7:0] wdata;

  sync_ram_sp_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ia ();
  sync_ram_sp_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ib ();

  assign ia.en = en;  assign ia.we = we;  assign ia.clr = clr;
  assign ia.addr = addr;  assign ia.wdata = wdata;
  assign ib.en = en;  assign ib.we = we;  assign ib.clr = clr;
  assign ib.addr = addr;  assign ib.wdata = wdata;

  sync_ram_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  sync_ram_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  typedef struct {
    logic       en, we, clr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       dut_b;
    logic       busy, rvalid, oob, chk_rdata;
    logic [7:0] rdata;
    string      name;
  } vec_t;

  typedef struct {
    logic       dut_b;
    logic       busy, rvalid, oob, chk_rdata;
    logic [7:0] rdata;
    string      name;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mkv(input logic e, input logic w, input logic [3:0] a,
                               input logic [7:0] d, input logic c, input logic b,
                               input logic xbusy, input logic xrv, input logic xoob,
                               input logic xchk, input logic [7:0] xrd, input string nm);
    vec_t v;
    v.en = e; v.we = w; v.addr = a; v.wdata = d; v.clr = c; v.dut_b = b;
    v.busy = xbusy; v.rvalid = xrv; v.oob = xoob; v.chk_rdata = xchk; v.rdata = xrd;
    v.name = nm;
    return v;
  endfunction

  task automatic compare(input exp_t e);
    logic       b, rv, ob;
    logic [7:0] rd;
    b  = e.dut_b ? ib.busy   : ia.busy;
    rv = e.dut_b ? ib.rvalid : ia.rvalid;
    ob = e.dut_b ? ib.oob    : ia.oob;
    rd = e.dut_b ? ib.rdata  : ia.rdata;
    n_vec++;
    if (b !== e.busy || rv !== e.rvalid || ob !== e.oob ||
        (e.chk_rdata && rd !== e.rdata)) begin
      n_bad++;
      $display("FAIL %s (dut %s) t=%0t: got busy=%0b rvalid=%0b oob=%0b rdata=%02h, want busy=%0b rvalid=%0b oob=%0b rdata=%s",
               e.name, e.dut_b ? "B" : "A", $time, b, rv, ob, rd,
               e.busy, e.rvalid, e.oob,
               e.chk_rdata ? $sformatf("%02h", e.rdata) : "any");
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample #1 after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    en = v.en; we = v.we; clr = v.clr; addr = v.addr; wdata = v.wdata;
    e.dut_b = v.dut_b; e.busy = v.busy; e.rvalid = v.rvalid; e.oob = v.oob;
    e.chk_rdata = v.chk_rdata; e.rdata = v.rdata; e.name = v.name;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty: got no entry, want one for %s", v.name);
    end else begin
      compare(sbq.pop_front());
    end
  endtask

  task automatic check_reset(input string nm);
    exp_t e;
    e.dut_b = 1'b0; e.busy = 1'b1; e.rvalid = 1'b0; e.oob = 1'b0;
    e.chk_rdata = 1'b1; e.rdata = 8'h00; e.name = nm;
    compare(e);
  endtask

  initial begin
    // Main table: back-to-back write burst then read burst on instance A.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mkv(1, 1, 4'(k), 8'(8'hA0 + k), 0, 0, 0, 0, 0, 1, 8'h00, "wr_burst"));
    for (int k = 0; k < 16; k++)
      tbl.push_back(mkv(1, 0, 4'(k), 8'h00, 0, 0, 0, 1, 0, 1, 8'(8'hA0 + k), "rd_burst"));
    tbl.push_back(mkv(1, 1, 4'd5, 8'h5A, 0, 0, 0, 0, 0, 1, 8'hAF, "wr5"));
    tbl.push_back(mkv(1, 0, 4'd5, 8'h00, 0, 0, 0, 1, 0, 1, 8'h5A, "rd5"));
    tbl.push_back(mkv(0, 0, 4'd5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h5A, "idle_hold"));
    tbl.push_back(mkv(0, 1, 4'd9, 8'h33, 0, 0, 0, 0, 0, 1, 8'h5A, "idle_hold_we"));

    // Reset state, checked with no clock edge yet.
    rst_n = 1'b0; en = 1'b1; we = 1'b0; addr = 4'd3; wdata = 8'h00; clr = 1'b0;
    #2;
    check_reset("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clear engine after reset release: 16 busy edges, read request ignored.
    for (int k = 1; k <= 16; k++)
      apply(mkv(1, 0, 4'd3, 8'h00, 0, 0, (k < 16), 0, 0, 1, 8'h00, "post_reset_clear"));
    apply(mkv(1, 0, 4'd3, 8'h00, 0, 0, 0, 1, 0, 1, 8'h00, "first_read"));

    foreach (tbl[i]) apply(tbl[i]);

    // clr with a same-cycle write: write dropped, rdata survives the clear.
    apply(mkv(1, 1, 4'd2, 8'hFF, 1, 0, 1, 0, 0, 1, 8'h5A, "clr_with_write"));
    for (int k = 1; k <= 16; k++)
      apply(mkv(1, 0, 4'd2, 8'h00, 0, 0, (k < 16), 0, 0, 1, 8'h5A, "clr_busy"));
    for (int k = 0; k < 16; k++)
      apply(mkv(1, 0, 4'(k), 8'h00, 0, 0, 0, 1, 0, 1, 8'h00, "rd_after_clr"));

    // clr again at cycle 8 of a clear: busy lasts 16 cycles from the restart.
    apply(mkv(1, 1, 4'd7, 8'h3C, 0, 0, 0, 0, 0, 1, 8'h00, "wr7"));
    apply(mkv(0, 0, 4'd0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, "clr_first"));
    for (int k = 1; k <= 7; k++)
      apply(mkv(0, 0, 4'd0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, "clr_pre_restart"));
    apply(mkv(0, 0, 4'd0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, "clr_restart"));
    for (int k = 1; k <= 16; k++)
      apply(mkv(0, 0, 4'd0, 8'h00, 0, 0, (k < 16), 0, 0, 0, 8'h00, "clr_after_restart"));
    apply(mkv(1, 0, 4'd7, 8'h00, 0, 0, 0, 1, 0, 1, 8'h00, "rd7_after_clr"));

    // DEPTH=12 instance: out-of-range accesses at and beyond DEPTH.
    apply(mkv(1, 1, 4'd1,  8'h01, 0, 1, 0, 0, 0, 0, 8'h00, "b_wr1"));
    apply(mkv(1, 1, 4'd11, 8'h11, 0, 1, 0, 0, 0, 0, 8'h00, "b_wr11"));
    apply(mkv(1, 1, 4'd13, 8'h77, 0, 1, 0, 0, 1, 0, 8'h00, "b_wr13_oob"));
    apply(mkv(1, 1, 4'd12, 8'h66, 0, 1, 0, 0, 1, 0, 8'h00, "b_wr12_oob"));
    apply(mkv(1, 0, 4'd13, 8'h00, 0, 1, 0, 1, 1, 1, 8'h00, "b_rd13_oob"));
    apply(mkv(1, 0, 4'd11, 8'h00, 0, 1, 0, 1, 0, 1, 8'h11, "b_rd11"));
    apply(mkv(1, 0, 4'd12, 8'h00, 0, 1, 0, 1, 1, 1, 8'h00, "b_rd12_oob"));
    apply(mkv(1, 0, 4'd1,  8'h00, 0, 1, 0, 1, 0, 1, 8'h01, "b_rd1"));
    apply(mkv(0, 0, 4'd1,  8'h00, 0, 1, 0, 0, 0, 1, 8'h01, "b_idle"));

    // Reset in the middle of a read burst on instance A.
    apply(mkv(1, 1, 4'd0, 8'h99, 0, 0, 0, 0, 0, 0, 8'h00, "wr0"));
    apply(mkv(1, 0, 4'd0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h99, "rd0_burst"));
    apply(mkv(1, 0, 4'd0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h99, "rd0_burst"));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_read");
    @(posedge clk);
    #1;
    check_reset("reset_held_edge");
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++)
      apply(mkv(1, 0, 4'd0, 8'h00, 0, 0, (k < 16), 0, 0, 1, 8'h00, "reclear"));
    apply(mkv(1, 0, 4'd0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h00, "rd0_after_reclear"));

    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
